wb_initiator: RTL and testbench
===============================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of cycles in BUS while waiting for ack (legal range 2..255).
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF, SHALL be the rsp_dat value returned on timeout.
REQ-003 One clock and one reset; reset is asynchronous and active-low. Ports: wb_clk_i, input, 1, clock; wb_rst_ni, input, 1, asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command request; cmd_ready  output  1  command accepted when both are high.
REQ-005 cmd_we  input  1  write=1/read=0; cmd_adr  input  32  byte address; cmd_dat  input  32  write data; cmd_sel  input  4  byte lanes.
REQ-006 rsp_valid  output  1  response available; rsp_ready  input  1  response consumed when both are high.
REQ-007 rsp_dat  output  32  read data, or ERR_DATA on timeout; rsp_err  output  1  timeout flag.
REQ-008 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each; wbm_adr_o  output  32; wbm_dat_o  output  32; wbm_sel_o  output  4.
REQ-009 wbm_ack_i  input  1; wbm_dat_i  input  32; busy  output  1  high in any state other than IDLE.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, BUS and RESP.
REQ-011 IDLE: cmd_ready=1 (combinational from state); cmd_valid&&cmd_ready SHALL register we/adr/dat/sel and move to BUS on the same edge.
REQ-012 BUS: wbm_cyc_o=wbm_stb_o=1 and wbm_we_o/adr/dat/sel SHALL be held stable from registers; the first BUS cycle is the cycle after acceptance.
REQ-013 wbm_ack_i sampled high in BUS SHALL deassert cyc/stb on that edge, capture wbm_dat_i into rsp_dat for reads (rsp_dat=0 for writes), clear rsp_err, and enter RESP.
REQ-014 A timeout counter SHALL clear on BUS entry and increment each BUS cycle without ack; with the counter at TIMEOUT_CYCLES-1 and no ack, the block SHALL deassert cyc/stb, set rsp_err=1, set rsp_dat=ERR_DATA and enter RESP.
REQ-015 Simultaneous ack and timeout expiry: ack SHALL win (normal completion, rsp_err=0).
REQ-016 RESP: rsp_valid=1, with rsp_dat and rsp_err stable until rsp_valid&&rsp_ready, then IDLE; cmd_ready=0 in RESP (no back-to-back overlap).
REQ-017 wbm_ack_i in IDLE or RESP SHALL be ignored, with no state or data change.
REQ-018 Best-case latency SHALL be: accept at edge N, cyc/stb high in cycle N+1, ack at edge N+1, rsp_valid high in cycle N+2.
REQ-019 wbm_cyc_o and wbm_stb_o SHALL be asserted together and SHALL never be high outside BUS.

Reset
REQ-020 wb_rst_ni low SHALL asynchronously force IDLE and drive all outputs low (cmd_ready returns to 1 when reset is released), including in the middle of a BUS transaction; no response SHALL be produced for an aborted command.
REQ-021 Reset SHALL clear the timeout counter, rsp_dat, rsp_err and all registered command fields to 0.

Configuration
REQ-022 Macro WB_INITIATOR_TIMEOUT_EN defined: the timeout counter and the ERR_DATA path SHALL be compiled in as in REQ-014/015.
REQ-023 Macro WB_INITIATOR_TIMEOUT_EN undefined: BUS SHALL wait indefinitely for ack, rsp_err SHALL be tied 0, and the counter logic SHALL be absent.

Verification
REQ-024 Write cmd adr=32'h3000_0000, dat=32'h0000_00A5, sel=4'hF; slave acks in the first BUS cycle -> cyc/stb high for exactly 1 cycle, rsp_valid next cycle, rsp_err=0, rsp_dat=0.
REQ-025 Read cmd adr=32'h3000_0004; slave returns 32'hAA55_3311 with ack after 3 wait cycles -> rsp_dat=32'hAA55_3311, rsp_err=0, cyc high for 4 cycles.
REQ-026 Read with no ack, TIMEOUT_CYCLES=16, macro defined -> cyc/stb high for exactly 16 cycles, rsp_err=1, rsp_dat=32'hDEAD_BEEF.
REQ-027 Ack asserted on the 16th BUS cycle (expiry cycle) with wbm_dat_i=32'h1234_5678 -> rsp_err=0, rsp_dat=32'h1234_5678.
REQ-028 rsp_ready held low for 5 cycles in RESP while a new cmd_valid is presented -> rsp_valid and data stay stable, cmd_ready=0, and the new command is accepted only after the response is consumed.
REQ-029 wb_rst_ni pulsed low for 1 cycle mid-BUS -> cyc/stb drop immediately, FSM returns to IDLE, no rsp_valid, and the next command completes normally.

Source files
------------

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus cycle, one response out.
// Optional ack timeout with ERR_DATA response is compiled in by defining WB_INITIATOR_TIMEOUT_EN.
module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and payloads stay stable while valid waits for ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic [31:0] rsp_dat_q;
    logic        accept;
    logic        ack_hit;
    logic        timeout_hit;

    assign accept  = (state_q == IDLE) && cmd_valid;
    assign ack_hit = (state_q == BUS) && wbm_ack_i;

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic       rsp_err_q;

    // Ack on the expiry cycle is a normal completion, so expiry requires !ack.
    assign timeout_hit = (state_q == BUS) && !wbm_ack_i && (cnt_q == TO_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
            end else if ((state_q == BUS) && !wbm_ack_i) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (ack_hit) begin
                rsp_err_q <= 1'b0;
            end else if (timeout_hit) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign rsp_err = rsp_err_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{ERR_DATA, TIMEOUT_CYCLES};
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = BUS;
            BUS:     if (wbm_ack_i || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
        end else begin
            if (accept) begin
                we_q  <= cmd_we;
                adr_q <= cmd_adr;
                dat_q <= cmd_dat;
                sel_q <= cmd_sel;
            end
            // Writes return zero data so a stale read value never leaks into a write response.
            if (ack_hit) begin
                rsp_dat_q <= we_q ? 32'h0 : wbm_dat_i;
            end
`ifdef WB_INITIATOR_TIMEOUT_EN
            else if (timeout_hit) begin
                rsp_dat_q <= ERR_DATA;
            end
`endif
        end
    end

    // cmd_ready is gated by reset so every output reads low while reset is held.
    assign cmd_ready = wb_rst_ni && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_dat   = rsp_dat_q;
    assign wbm_cyc_o = (state_q == BUS);
    assign wbm_stb_o = (state_q == BUS);
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: directed cases plus randomized commands against a
// transaction-level model (cycle counts and response values derived from wait count and timeout).
module tb_wb_initiator;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        busy;
    logic [1:0]  state_dbg;

    wb_initiator #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rsp = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver: one full command/bus/response transaction; slave acks on BUS cycle waits+1.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int waits, input logic [31:0] rdata,
                           input int hold);
        bit          timed_out;
        int          exp_cycles;
        int          cyc_cnt;
        logic        exp_err;
        logic [31:0] exp_dat;
        logic        bus_ok;
        logic        hold_ok;
        timed_out  = TO_EN && (waits >= TO);
        exp_cycles = timed_out ? TO : waits + 1;
        exp_err    = timed_out;
        exp_dat    = timed_out ? ERR : (we ? 32'h0 : rdata);
        exp_q.push_back(exp_dat);

        check("idle_ready", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = ~sel;
        check("first_bus_cyc", {31'h0, wbm_cyc_o}, 32'h1);

        cyc_cnt = 0;
        bus_ok  = 1'b1;
        while (wbm_cyc_o === 1'b1 && cyc_cnt < 300) begin
            cyc_cnt++;
            bus_ok = bus_ok && (wbm_stb_o === 1'b1) && (wbm_we_o === we) && (wbm_adr_o === adr)
                     && (wbm_dat_o === dat) && (wbm_sel_o === sel) && (cmd_ready === 1'b0)
                     && (busy === 1'b1) && (rsp_valid === 1'b0);
            wbm_ack_i = (cyc_cnt == waits + 1);
            wbm_dat_i = wbm_ack_i ? rdata : $urandom;
            @(posedge clk); @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = $urandom;
        check("bus_hold", {31'h0, bus_ok}, 32'h1);
        check("cyc_cycles", cyc_cnt, exp_cycles);
        check("stb_after", {31'h0, wbm_stb_o}, 32'h0);
        check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
        check("rsp_dat", rsp_dat, exp_q.pop_front());

        hold_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1; cmd_we = $urandom; cmd_adr = $urandom; cmd_dat = $urandom;
            wbm_ack_i = $urandom; wbm_dat_i = $urandom;
            @(posedge clk); @(negedge clk);
            hold_ok = hold_ok && (rsp_valid === 1'b1) && (rsp_dat === exp_dat)
                      && (rsp_err === exp_err) && (cmd_ready === 1'b0) && (wbm_cyc_o === 1'b0);
        end
        cmd_valid = 1'b0; wbm_ack_i = 1'b0;
        if (hold > 0) check("rsp_stall_stable", {31'h0, hold_ok}, 32'h1);

        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_consumed", {30'h0, rsp_valid, busy}, 32'h0);
        check("ready_again", {31'h0, cmd_ready}, 32'h1);
        last_rsp = exp_dat;
    endtask

    // Reset pulse in the middle of a bus cycle that the slave never acks.
    task automatic reset_mid_bus();
        logic quiet;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h4000_0010; cmd_sel = 4'hF;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_cyc", {31'h0, wbm_cyc_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_cyc_stb", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
        check("rst_busy_ready", {30'h0, busy, cmd_ready}, 32'h0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_rsp", {rsp_dat[30:0], rsp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", {31'h0, cmd_ready}, 32'h1);
        quiet = 1'b1;
        repeat (TO + 4) begin
            @(negedge clk);
            quiet = quiet && (rsp_valid === 1'b0) && (wbm_cyc_o === 1'b0) && (busy === 1'b0);
        end
        check("no_rsp_after_abort", {31'h0, quiet}, 32'h1);
        last_rsp = 32'h0;
    endtask

    initial begin
        logic        idle_ok;
        logic        rw;
        int          waits;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
        repeat (2) @(negedge clk);
        check("reset_ready_low", {31'h0, cmd_ready}, 32'h0);
        check("reset_bus", {29'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'h0);
        check("reset_adr_dat", wbm_adr_o | wbm_dat_o | {28'h0, wbm_sel_o}, 32'h0);
        check("reset_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        check("reset_rsp_dat", rsp_dat, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", {30'h0, cmd_ready, busy}, 32'h2);

        run_txn(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF, 0, 32'h7777_7777, 0);
        run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 32'hAA55_3311, 0);
`ifdef WB_INITIATOR_TIMEOUT_EN
        run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1000, 32'h0, 0);
        run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, TO - 1, 32'h1234_5678, 0);
`endif
        run_txn(1'b0, 32'h3000_0010, 32'h0, 4'h3, 2, 32'hCAFE_0001, 5);

        // Stray acks while idle must not disturb state or response data.
        idle_ok = 1'b1;
        repeat (4) begin
            wbm_ack_i = 1'b1; wbm_dat_i = $urandom;
            @(posedge clk); @(negedge clk);
            idle_ok = idle_ok && (busy === 1'b0) && (cmd_ready === 1'b1) && (rsp_valid === 1'b0)
                      && (rsp_dat === last_rsp) && (wbm_cyc_o === 1'b0);
        end
        wbm_ack_i = 1'b0;
        check("idle_ack_ignored", {31'h0, idle_ok}, 32'h1);

        reset_mid_bus();
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 0);

        for (int i = 0; i < 25; i++) begin
            rw    = $urandom_range(0, 1);
            waits = $urandom_range(0, 6);
            if (TO_EN && ($urandom_range(0, 3) == 0)) waits = $urandom_range(TO - 2, TO + 4);
            run_txn(rw, $urandom, $urandom, 4'($urandom_range(0, 15)), waits, $urandom,
                    $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
